// File: rtl/key_event_arbiter.sv
// Round-robin arbiter that turns per-key press pulses into a FIFO-buffered stream of key codes.
// Optional saturating dropped-press counter is enabled by defining KEY_ARB_DROPCNT_EN.
module key_event_arbiter #(
    parameter int NKEYS      = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [NKEYS-1:0] pulse_in,
    output logic             evt_valid,
    output logic [1:0]       evt_code,
    input  logic             evt_ready,
    output logic [NKEYS-1:0] pending,
    output logic             fifo_full
`ifdef KEY_ARB_DROPCNT_EN
    ,
    output logic [7:0]       drop_count
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [1:0]    LAST_KEY  = 2'(NKEYS - 1);
    localparam logic [AW:0]   DEPTH_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE   = AW'(1);

    typedef enum logic {IDLE, GRANT} arb_state_t;

    arb_state_t       state_reg;
    logic [NKEYS-1:0] pending_reg, pending_next, grant_onehot;
    logic [1:0]       rr_ptr_reg, gnt_idx;
    logic [1:0]       mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [AW:0]      count_reg, count_next;
    logic             full_reg, valid_reg;
    logic             push, pop;

    assign push = (state_reg == GRANT);
    assign pop  = valid_reg & evt_ready;

    // Search upward from the round-robin pointer, wrapping at NKEYS
    always_comb begin
        logic found;
        int   j;
        found   = 1'b0;
        j       = 0;
        gnt_idx = '0;
        for (int k = 0; k < NKEYS; k++) begin
            j = int'(rr_ptr_reg) + k;
            if (j >= NKEYS) j = j - NKEYS;
            if (!found && pending_reg[j]) begin
                found   = 1'b1;
                gnt_idx = 2'(j);
            end
        end
    end

    // A pulse on the key being granted re-arms its pending bit instead of counting as a drop
    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_key
        assign grant_onehot[gi] = push && (gnt_idx == 2'(gi));
        assign pending_next[gi] = pulse_in[gi] | (pending_reg[gi] & ~grant_onehot[gi]);
    end

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CNT_ONE;
        else if (pop && !push)
            count_next = count_reg - CNT_ONE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg   <= IDLE;
            pending_reg <= '0;
            rr_ptr_reg  <= '0;
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            full_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            pending_reg <= pending_next;
            count_reg   <= count_next;
            full_reg    <= (count_next == DEPTH_CNT);
            valid_reg   <= (count_next != '0);
            state_reg   <= ((|pending_next) && (count_next != DEPTH_CNT)) ? GRANT : IDLE;
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
                rr_ptr_reg <= (gnt_idx == LAST_KEY) ? 2'd0 : gnt_idx + 2'd1;
            end
            if (pop)
                rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        end
    end

    // Storage needs no reset: entries are only visible while valid
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= gnt_idx;
    end

    assign evt_valid = valid_reg;
    assign evt_code  = valid_reg ? mem[rd_ptr_reg] : 2'd0;
    assign pending   = pending_reg;
    assign fifo_full = full_reg;

`ifdef KEY_ARB_DROPCNT_EN
    logic [NKEYS-1:0] drop_vec;
    logic [7:0]       drop_cnt_reg;
    logic [8:0]       drop_sum;

    for (genvar gi = 0; gi < NKEYS; gi++) begin : g_drop
        assign drop_vec[gi] = pulse_in[gi] & pending_reg[gi] & ~grant_onehot[gi];
    end

    always_comb begin
        drop_sum = {1'b0, drop_cnt_reg};
        for (int i = 0; i < NKEYS; i++)
            drop_sum = drop_sum + 9'(drop_vec[i]);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            drop_cnt_reg <= '0;
        else
            drop_cnt_reg <= (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
    end

    assign drop_count = drop_cnt_reg;
`endif
endmodule

// File: tb/tb_key_event_arbiter.sv
// Scoreboard bench for key_event_arbiter: a queue-based reference model predicts events and state,
// a negedge monitor compares the DUT against it.
module tb_key_event_arbiter;
    localparam int NKEYS = 4;
    localparam int DEPTH = 4;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [NKEYS-1:0] pulse_in = '0;
    logic             evt_ready = 1'b0;
    logic             evt_valid;
    logic [1:0]       evt_code;
    logic [NKEYS-1:0] pending;
    logic             fifo_full;
`ifdef KEY_ARB_DROPCNT_EN
    logic [7:0]       drop_count;
`endif

    key_event_arbiter #(.NKEYS(NKEYS), .FIFO_DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .pulse_in  (pulse_in),
        .evt_valid (evt_valid),
        .evt_code  (evt_code),
        .evt_ready (evt_ready),
        .pending   (pending),
        .fifo_full (fifo_full)
`ifdef KEY_ARB_DROPCNT_EN
        ,
        .drop_count(drop_count)
`endif
    );

    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit [NKEYS-1:0] m_pend = '0;
    int             m_ptr = 0;
    int             m_drop = 0;
    int             m_q[$];
    int             exp_q[$];

    initial begin : model
        int g;
        int n;
        int j;
        forever begin
            @(posedge clk or negedge reset_n);
            if (!reset_n) begin
                m_pend = '0;
                m_ptr  = 0;
                m_drop = 0;
                m_q.delete();
                exp_q.delete();
            end else begin
                g = -1;
                if (m_pend != 0 && m_q.size() < DEPTH) begin
                    for (int k = 0; k < NKEYS; k++) begin
                        j = (m_ptr + k) % NKEYS;
                        if (g < 0 && m_pend[j]) g = j;
                    end
                end
                if (m_q.size() > 0 && evt_ready) void'(m_q.pop_front());
                n = 0;
                for (int i = 0; i < NKEYS; i++)
                    if (pulse_in[i] && m_pend[i] && g != i) n++;
                for (int i = 0; i < NKEYS; i++) begin
                    if (g == i) m_pend[i] = 1'b0;
                    if (pulse_in[i]) m_pend[i] = 1'b1;
                end
                if (g >= 0) begin
                    m_q.push_back(g);
                    exp_q.push_back(g);
                    m_ptr = (g + 1) % NKEYS;
                end
                m_drop = (m_drop + n > 255) ? 255 : m_drop + n;
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    initial begin : monitor
        int code;
        forever begin
            @(negedge clk);
            chk("evt_valid", int'(evt_valid), int'(m_q.size() != 0));
            chk("fifo_full", int'(fifo_full), int'(m_q.size() == DEPTH));
            chk("pending", int'(pending), int'(m_pend));
`ifdef KEY_ARB_DROPCNT_EN
            chk("drop_count", int'(drop_count), m_drop);
`endif
            if (!evt_valid) begin
                chk("evt_code_idle", int'(evt_code), 0);
            end else if (reset_n) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_event", int'(evt_code), -1);
                end else begin
                    chk("evt_code", int'(evt_code), exp_q[0]);
                    if (evt_ready) begin
                        code = exp_q.pop_front();
                        $display("evt code=%0d expected=%0d t=%0t", evt_code, code, $time);
                    end
                end
            end
        end
    end

    task automatic step(input logic [NKEYS-1:0] p, input logic r);
        @(posedge clk);
        #2;
        pulse_in  = p;
        evt_ready = r;
    endtask

    task automatic idle(input int n, input logic r);
        for (int i = 0; i < n; i++) step('0, r);
    endtask

    initial begin : stimulus
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        idle(2, 1'b1);

        // Single press
        step(4'b0001, 1'b1);
        idle(5, 1'b1);

        // Fairness
        step(4'b1111, 1'b1);
        idle(6, 1'b1);
        step(4'b0101, 1'b1);
        idle(4, 1'b1);
        step(4'b0101, 1'b1);
        idle(4, 1'b1);

        // Backpressure: five presses, FIFO of four
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0);
        idle(4, 1'b0);
        idle(8, 1'b1);

        // Drops against a full FIFO, saturating counter
        step(4'b0001, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b1000, 1'b0);
        step(4'b0001, 1'b0);
        idle(2, 1'b0);
        step(4'b0010, 1'b0);
        for (int i = 0; i < 300; i++) step(4'b0010, 1'b0);
        idle(8, 1'b1);

        // Grant collision on key 2
        step(4'b0100, 1'b1);
        step(4'b0100, 1'b1);
        idle(5, 1'b1);

        // Reset with three queued and two pending
        step(4'b0001, 1'b0);
        step(4'b0010, 1'b0);
        step(4'b0100, 1'b0);
        step(4'b0011, 1'b0);
        @(posedge clk);
        #2;
        pulse_in = '0;
        reset_n  = 1'b0;
        @(posedge clk);
        #2 reset_n = 1'b1;
        idle(6, 1'b1);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 3) == 0) ? NKEYS'($urandom) : '0,
                 ($urandom_range(0, 2) != 0));
        end
        idle(12, 1'b1);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
